// File: rtl/ps_tx_vh.sv
// ps_tx_vh: serialise a parallel partial-sum vector to AGS and collect the hidden states it returns.
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   en                : global enable; low freezes state (AGS captures in WAIT still happen)
//   ps_valid/ps_vec   : parallel signed partial sums in, element k at [k*BW_PS +: BW_PS]
//   ps_ready          : high only while idle
//   data_out_en/_out  : registered serial partial-sum stream, element 0 first
//   new_state(_en)    : hidden-state bit returned by AGS for the current neuron
//   h_vec/h_vec_valid : collected hidden-state vector and its one-cycle completion pulse
//   proto_err         : sticky, set when AGS strobes new_state_en outside WAIT
module ps_tx_vh #(
  parameter int BW_PS      = 16,
  parameter int NUM_CORE_V = 16,
  parameter int NUM_HIDDEN = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          ps_valid,
  input  logic [NUM_CORE_V*BW_PS-1:0]   ps_vec,
  output logic                          ps_ready,
  output logic                          data_out_en,
  output logic [BW_PS-1:0]              data_out,
  input  logic                          new_state,
  input  logic                          new_state_en,
  output logic [NUM_HIDDEN-1:0]         h_vec,
  output logic                          h_vec_valid,
  output logic                          proto_err
);
  localparam int IW = NUM_CORE_V > 1 ? $clog2(NUM_CORE_V) : 1;
  localparam int HW = NUM_HIDDEN > 1 ? $clog2(NUM_HIDDEN) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(NUM_CORE_V - 1);
  localparam logic [HW-1:0] H_LAST = HW'(NUM_HIDDEN - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t                      state_q, state_d;
  logic [NUM_CORE_V*BW_PS-1:0] buf_q, buf_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [HW-1:0]               hidx_q, hidx_d;
  logic [BW_PS-1:0]            data_out_q, data_out_d;
  logic                        data_out_en_q, data_out_en_d;
  logic [NUM_HIDDEN-1:0]       h_vec_q, h_vec_d;
  logic                        h_vec_valid_q, h_vec_valid_d;
  logic                        proto_err_q, proto_err_d;
  logic                        accept, issue, capture, finish;

  assign accept  = state_q == IDLE && en && ps_valid;
  assign issue   = state_q == SEND && en;
  // AGS responses are honoured even while en is low
  assign capture = state_q == WAIT && new_state_en;
  assign finish  = state_q == DONE && en;

  always_comb begin
    state_d       = accept ? SEND :
                    (issue && idx_q == I_LAST) ? WAIT :
                    capture ? (hidx_q == H_LAST ? DONE : IDLE) :
                    finish ? IDLE : state_q;
    buf_d         = accept ? ps_vec : buf_q;
    idx_d         = accept ? '0 : issue ? idx_q + 1'b1 : idx_q;
    data_out_d    = issue ? buf_q[int'(idx_q)*BW_PS +: BW_PS] : data_out_q;
    data_out_en_d = issue;
    h_vec_d       = h_vec_q;
    if (capture) h_vec_d[hidx_q] = new_state;
    hidx_d        = capture ? (hidx_q == H_LAST ? '0 : hidx_q + 1'b1) : finish ? '0 : hidx_q;
    h_vec_valid_d = finish;
    proto_err_d   = proto_err_q | (new_state_en && state_q != WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      buf_q         <= '0;
      idx_q         <= '0;
      hidx_q        <= '0;
      data_out_q    <= '0;
      data_out_en_q <= 1'b0;
      h_vec_q       <= '0;
      h_vec_valid_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      idx_q         <= idx_d;
      hidx_q        <= hidx_d;
      data_out_q    <= data_out_d;
      data_out_en_q <= data_out_en_d;
      h_vec_q       <= h_vec_d;
      h_vec_valid_q <= h_vec_valid_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign ps_ready    = state_q == IDLE;
  assign data_out    = data_out_q;
  assign data_out_en = data_out_en_q;
  assign h_vec       = h_vec_q;
  assign h_vec_valid = h_vec_valid_q;
  assign proto_err   = proto_err_q;
endmodule

// File: tb/tb_ps_tx_vh.sv
// tb_ps_tx_vh: randomized self-checking bench for ps_tx_vh against a behavioural model.
module tb_ps_tx_vh;
  localparam int BW = 16;
  localparam int NV = 16;
  localparam int NH = 32;

  logic             clk = 1'b0;
  logic             rst, en, ps_valid, ps_ready, data_out_en;
  logic             new_state, new_state_en, h_vec_valid, proto_err;
  logic [NV*BW-1:0] ps_vec;
  logic [BW-1:0]    data_out;
  logic [NH-1:0]    h_vec;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [BW-1:0] el [NV];
  logic [BW-1:0] dout_mdl;
  logic [NH-1:0] h_mdl;
  int            hi;

  always #5 clk = ~clk;

  ps_tx_vh #(.BW_PS(BW), .NUM_CORE_V(NV), .NUM_HIDDEN(NH)) dut (
    .clk(clk), .rst(rst), .en(en), .ps_valid(ps_valid), .ps_vec(ps_vec),
    .ps_ready(ps_ready), .data_out_en(data_out_en), .data_out(data_out),
    .new_state(new_state), .new_state_en(new_state_en), .h_vec(h_vec),
    .h_vec_valid(h_vec_valid), .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // kind 0: k-8 ramp, 1: alternating max/min, 2: random
  task automatic load(input int kind);
    for (int k = 0; k < NV; k++) begin
      el[k] = kind == 0 ? BW'(k - 8) : kind == 1 ? (k % 2 == 1 ? 16'h8000 : 16'h7fff) : BW'($urandom);
      ps_vec[k*BW +: BW] = el[k];
    end
  endtask

  // mode 0: en always high, 1: random en, 2: en high on every other edge
  task automatic neuron(input int mode, input logic ns);
    int   got, k;
    logic e;
    ps_valid = 1'b1;
    en = 1'b1;
    chk("ready_idle", ps_ready, 1);
    @(negedge clk);
    chk("gap_dout_en", data_out_en, 0);
    chk("ready_busy", ps_ready, 0);
    got = 0;
    k = 0;
    while (got < NV && k < 200) begin
      k++;
      e = mode == 0 ? 1'b1 : mode == 2 ? (k % 2 == 0) : ($urandom_range(0, 3) != 0);
      en = e;
      @(negedge clk);
      chk("dout_en", data_out_en, e);
      if (e) begin
        chk("dout", data_out, el[got]);
        dout_mdl = el[got];
        got++;
      end else chk("dout_hold", data_out, dout_mdl);
    end
    chk("strobes", got, NV);
    if (mode != 1) chk("send_cycles", k, mode == 0 ? NV : 2 * NV);
    en = 1'($urandom_range(0, 1));
    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      chk("wait_dout_en", data_out_en, 0);
      chk("wait_ready", ps_ready, 0);
    end
    new_state = ns;
    new_state_en = 1'b1;
    @(negedge clk);
    new_state_en = 1'b0;
    h_mdl[hi] = ns;
    hi = (hi + 1) % NH;
    chk("h_vec", h_vec, h_mdl);
    chk("capture_dout_en", data_out_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; ps_valid = 1'b0; ps_vec = '0;
    new_state = 1'b0; new_state_en = 1'b0;
    h_mdl = '0; hi = 0; dout_mdl = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ps_ready, 1);
    chk("rst_dout_en", data_out_en, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_h_vec", h_vec, 0);
    chk("rst_hvv", h_vec_valid, 0);
    chk("rst_perr", proto_err, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NH; i++) begin
      load(i == 0 ? 0 : i == 1 ? 1 : 2);
      neuron(i == 2 ? 2 : i < 2 ? 0 : 1, i % 2 == 1);
    end
    ps_valid = 1'b0;
    en = 1'b1;
    chk("done_hvv_early", h_vec_valid, 0);
    chk("done_ready", ps_ready, 0);
    @(negedge clk);
    chk("done_hvv", h_vec_valid, 1);
    chk("pass_h_vec", h_vec, 32'haaaaaaaa);
    chk("done_ready_after", ps_ready, 1);
    @(negedge clk);
    chk("done_hvv_once", h_vec_valid, 0);
    chk("perr_clean", proto_err, 0);
    for (int i = 0; i < 10; i++) begin
      load(2);
      neuron(1, 1'($urandom_range(0, 1)));
    end
    ps_valid = 1'b0;
    en = 1'($urandom_range(0, 1));
    new_state = ~h_mdl[hi];
    new_state_en = 1'b1;
    @(negedge clk);
    new_state_en = 1'b0;
    chk("perr_set", proto_err, 1);
    chk("perr_h_vec", h_vec, h_mdl);
    chk("perr_ready", ps_ready, 1);
    repeat (3) @(negedge clk);
    chk("perr_sticky", proto_err, 1);
    load(1);
    neuron(0, 1'b1);
    chk("perr_sticky_after", proto_err, 1);
    load(2);
    ps_valid = 1'b1;
    en = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre_rst_dout_en", data_out_en, 1);
    chk("pre_rst_dout", data_out, el[4]);
    #2 rst = 1'b1;
    #1;
    chk("arst_dout_en", data_out_en, 0);
    chk("arst_dout", data_out, 0);
    chk("arst_h_vec", h_vec, 0);
    chk("arst_hvv", h_vec_valid, 0);
    chk("arst_perr", proto_err, 0);
    chk("arst_ready", ps_ready, 1);
    ps_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    h_mdl = '0; hi = 0; dout_mdl = '0;
    @(negedge clk);
    chk("post_rst_ready", ps_ready, 1);
    chk("post_rst_dout_en", data_out_en, 0);
    load(0);
    neuron(0, 1'b1);
    chk("post_rst_h_vec", h_vec, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
